// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, unit count, result width and FSM state encoding shared by the ALU sequencer
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam int NUM_UNITS = 6;
  localparam int RES_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/alu_res_mux.sv
// alu_res_mux: picks the selected unit's result slice; out-of-range selects give zero
module alu_res_mux import alu_pkg::*; #(
  parameter int NUM_UNITS = alu_pkg::NUM_UNITS
) (
  input  logic [2:0]                 sel_i,
  input  logic [RES_W*NUM_UNITS-1:0] unit_res_i,
  output logic [RES_W-1:0]           res_o
);
  // a true select, not an OR of all slices, so stray outputs from other units are ignored
  always_comb begin
    res_o = '0;
    for (int i = 0; i < NUM_UNITS; i++) res_o = (int'(sel_i) == i) ? unit_res_i[RES_W*i +: RES_W] : res_o;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU command, enables one unit for a settle window, returns its result
module alu_op_sequencer import alu_pkg::*; #(
  parameter int NUM_UNITS  = alu_pkg::NUM_UNITS,
  parameter int SETTLE_CYC = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [3:0]                 cmd_a,
  input  logic [3:0]                 cmd_b,
  output logic [NUM_UNITS-1:0]       unit_en,
  output logic [3:0]                 unit_a,
  output logic [3:0]                 unit_b,
  input  logic [RES_W*NUM_UNITS-1:0] unit_res,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [RES_W-1:0]           rsp_data,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [7:0]                 op_count
);
  state_e           state_q;
  logic [2:0]       op_q;
  logic [3:0]       cnt_q;
  logic [3:0]       a_q;
  logic [3:0]       b_q;
  logic [RES_W-1:0] data_q;
  logic             err_q;
  logic [7:0]       count_q;
  logic [RES_W-1:0] sel_res;
  alu_res_mux #(.NUM_UNITS(NUM_UNITS)) u_mux (
    .sel_i      (op_q),
    .unit_res_i (unit_res),
    .res_o      (sel_res)
  );
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign rsp_valid = state_q == DONE;
  assign unit_en   = (state_q == EXEC) ? {{(NUM_UNITS-1){1'b0}}, 1'b1} << op_q : '0;
  assign unit_a    = a_q;
  assign unit_b    = b_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign op_count  = count_q;
  // command accept, settle countdown, result capture and response handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          op_q  <= cmd_op;
          a_q   <= cmd_a;
          b_q   <= cmd_b;
          cnt_q <= 4'(SETTLE_CYC - 1);
          if (int'(cmd_op) < NUM_UNITS) state_q <= EXEC;
          else begin
            state_q <= DONE;
            data_q  <= '0;
            err_q   <= 1'b1;
          end
        end
        EXEC: if (cnt_q == 4'd0) begin
          data_q  <= sel_res;
          err_q   <= 1'b0;
          state_q <= DONE;
        end else cnt_q <= cnt_q - 4'd1;
        DONE: if (rsp_ready) begin
          count_q <= count_q + 8'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of two sequencers (settle 1 and 3) against a behavioural unit bank
module tb_alu_op_sequencer;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] op = '0;
  logic [3:0] a = '0, b = '0;
  logic v1 = 1'b0, r1 = 1'b0, v3 = 1'b0, r3 = 1'b0;
  logic cr1, cr3, rv1, rv3, re1, re3, bz1, bz3;
  logic [5:0] en1, en3;
  logic [3:0] ua1, ub1, ua3, ub3;
  logic [7:0] rd1, rd3, oc1, oc3;
  logic [47:0] res1, res3;
  int checks = 0, errors = 0, resp = 0;
  always #5 clk = ~clk;
  function automatic logic [47:0] bank(input logic [5:0] en, input logic [3:0] x, input logic [3:0] y);
    bank = {en[5] ? 8'({4'b0, x} * {4'b0, y}) : 8'h00,
            en[4] ? {4'b0, x ^ y} : 8'h00,
            en[3] ? {4'b0, x | y} : 8'h00,
            en[2] ? {4'b0, x & y} : 8'h00,
            en[1] ? 8'({4'b0, x} - {4'b0, y}) : 8'h00,
            en[0] ? 8'({4'b0, x} + {4'b0, y}) : 8'h00};
  endfunction
  assign res1 = bank(en1, ua1, ub1);
  assign res3 = bank(en3, ua3, ub3);
  alu_op_sequencer #(.NUM_UNITS(6), .SETTLE_CYC(1)) d1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(cr1), .cmd_op(op), .cmd_a(a), .cmd_b(b),
    .unit_en(en1), .unit_a(ua1), .unit_b(ub1), .unit_res(res1), .rsp_valid(rv1), .rsp_ready(r1),
    .rsp_data(rd1), .rsp_err(re1), .busy(bz1), .op_count(oc1));
  alu_op_sequencer #(.NUM_UNITS(6), .SETTLE_CYC(3)) d3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v3), .cmd_ready(cr3), .cmd_op(op), .cmd_a(a), .cmd_b(b),
    .unit_en(en3), .unit_a(ua3), .unit_b(ub3), .unit_res(res3), .rsp_valid(rv3), .rsp_ready(r3),
    .rsp_data(rd3), .rsp_err(re3), .busy(bz3), .op_count(oc3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cr1, 1);
    chk("rst_unit_en", en1, 0);
    chk("rst_unit_ab", {ua3, ub3}, 0);
    chk("rst_rsp", {rv1, re1, rd1}, 0);
    chk("rst_busy", bz3, 0);
    chk("rst_op_count", oc3, 0);
    rst_n = 1'b1;
    @(negedge clk);
    op = OP_OR; a = 4'hA; b = 4'h5; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    chk("or_en", en1, 6'b001000);
    chk("or_busy_ready", {bz1, cr1, rv1}, 3'b100);
    chk("or_unit_a", ua1, 4'hA);
    @(negedge clk);
    chk("or_en_drop", en1, 0);
    chk("or_rsp", {rv1, re1, rd1}, {2'b10, 8'h0F});
    r1 = 1'b1;
    @(negedge clk);
    r1 = 1'b0;
    chk("or_done", {rv1, cr1}, 2'b01);
    chk("or_count", oc1, 1);
    op = OP_MUL; a = 4'hF; b = 4'hF; v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mul_en", en3, 6'b100000);
      chk("mul_no_rsp", rv3, 0);
      @(negedge clk);
    end
    chk("mul_en_drop", en3, 0);
    chk("mul_rsp", {rv3, re3, rd3}, {2'b10, 8'hE1});
    r3 = 1'b1;
    @(negedge clk);
    r3 = 1'b0;
    chk("mul_count", oc3, 1);
    op = 3'd7; a = 4'h3; b = 4'h3; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    chk("ill_no_en", en1, 0);
    chk("ill_rsp", {rv1, re1, rd1}, {2'b11, 8'h00});
    r1 = 1'b1;
    @(negedge clk);
    r1 = 1'b0;
    chk("ill_count", oc1, 2);
    chk("ill_idle", {rv1, bz1}, 0);
    op = OP_AND; a = 4'hC; b = 4'hA; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);
    op = OP_SUB; a = 4'h3; b = 4'h5; v1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rv1, rd1}, {1'b1, 8'h08});
      chk("bp_busy", {bz1, cr1}, 2'b10);
      @(negedge clk);
    end
    r1 = 1'b1;
    @(negedge clk);
    r1 = 1'b0;
    chk("bp_count", oc1, 3);
    chk("bp_not_taken", {cr1, en1}, {1'b1, 6'b0});
    @(negedge clk);
    v1 = 1'b0;
    chk("bp_new_en", en1, 6'b000010);
    chk("bp_new_a", ua1, 4'h3);
    @(negedge clk);
    chk("bp_new_rsp", {rv1, re1, rd1}, {2'b10, 8'hFE});
    r1 = 1'b1;
    @(negedge clk);
    r1 = 1'b0;
    op = OP_ADD; a = 4'h2; b = 4'h3; v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    chk("rst_mid_en", en3, 6'b000001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en", en3, 0);
    chk("async_rsp", rv3, 0);
    chk("async_count", {oc3, oc1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_rsp", {rv3, re3, rd3}, {2'b10, 8'h05});
    r3 = 1'b1;
    @(negedge clk);
    r3 = 1'b0;
    chk("post_rst_count", oc3, 1);
    op = OP_ADD; a = 4'h7; b = 4'h9; v1 = 1'b1; r1 = 1'b1;
    for (int c = 0; c < 1000 && resp < 256; c++) begin
      @(negedge clk);
      chk("b2b_onehot", $countones(en1) <= 1, 1);
      if (rv1) begin
        chk("b2b_data", rd1, 8'h10);
        chk("b2b_count", oc1, 32'(resp[7:0]));
        resp++;
        if (resp == 256) v1 = 1'b0;
      end
    end
    @(negedge clk);
    r1 = 1'b0;
    chk("b2b_resp", resp, 256);
    chk("b2b_wrap", oc1, 0);
    chk("b2b_idle", {bz1, cr1}, 2'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
